// File: rtl/vga_mem_port_a_arbiter_if.sv
// Port A bus of the VGA frame memory arbiter: requester
// handshakes, clear-engine control and the raw memory port.
interface vga_mem_port_a_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
);
    logic                  clr_start;
    logic [DATA_WIDTH-1:0] clr_color;
    logic                  clr_busy;
    logic                  clr_done;

    logic                  w_req;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_gnt;

    logic                  r_req;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_gnt;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;

    logic [ADDR_WIDTH-1:0] mem_addr_a;
    logic [DATA_WIDTH-1:0] mem_data_a;
    logic                  mem_we_a;
    logic [DATA_WIDTH-1:0] mem_q_a;

    // Arbiter side.
    modport slave (
        input  clr_start, clr_color,
        input  w_req, w_addr, w_data,
        input  r_req, r_addr,
        input  mem_q_a,
        output clr_busy, clr_done,
        output w_gnt, r_gnt, r_valid, r_data,
        output mem_addr_a, mem_data_a, mem_we_a
    );

    // Requester / memory side.
    modport master (
        output clr_start, clr_color,
        output w_req, w_addr, w_data,
        output r_req, r_addr,
        output mem_q_a,
        input  clr_busy, clr_done,
        input  w_gnt, r_gnt, r_valid, r_data,
        input  mem_addr_a, mem_data_a, mem_we_a
    );
endinterface

// File: rtl/vga_mem_port_a_arbiter.sv
// Port A owner of the VGA frame memory: round-robin write/read
// arbitration plus a full-memory clear engine; outputs registered.
module vga_mem_port_a_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
) (
    input  logic clk,
    input  logic rst,
    vga_mem_port_a_arbiter_if.slave bus
);
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH:0] CNT_END = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                state_q;
    logic                  prio_w_q;
    logic                  w_gnt_q;
    logic                  r_gnt_q;
    logic                  we_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  rd_pend_q;
    logic                  r_valid_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] color_q;
    logic [DATA_WIDTH-1:0] r_data_q;
    logic [ADDR_WIDTH:0]   cnt_q;

    logic w_elig;
    logic r_elig;
    logic pick_w;
    logic pick_r;
    logic arb_en;
    logic clr_last;

    // Eligibility excludes a requester whose grant is still showing,
    // so nobody is served on two consecutive edges.
    always_comb begin
        w_elig   = bus.w_req & ~w_gnt_q;
        r_elig   = bus.r_req & ~r_gnt_q;
        pick_w   = w_elig & (~r_elig | prio_w_q);
        pick_r   = r_elig & ~pick_w;
        clr_last = (cnt_q == CNT_END);
        arb_en   = ((state_q == IDLE) & ~bus.clr_start) |
                   ((state_q == CLEAR) & clr_last);
    end

    // Controller FSM, read return pipeline and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            prio_w_q  <= 1'b1;
            w_gnt_q   <= 1'b0;
            r_gnt_q   <= 1'b0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_pend_q <= 1'b0;
            r_valid_q <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            color_q   <= '0;
            r_data_q  <= '0;
            cnt_q     <= '0;
        end else begin
            w_gnt_q   <= 1'b0;
            r_gnt_q   <= 1'b0;
            done_q    <= 1'b0;
            rd_pend_q <= r_gnt_q;
            r_valid_q <= rd_pend_q;
            if (rd_pend_q) begin
                r_data_q <= bus.mem_q_a;
            end

            unique case (state_q)
                IDLE: begin
                    if (bus.clr_start) begin
                        state_q <= CLEAR;
                        color_q <= bus.clr_color;
                        data_q  <= bus.clr_color;
                        addr_q  <= '0;
                        we_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        cnt_q   <= CNT_ONE;
                    end
                end
                CLEAR: begin
                    if (clr_last) begin
                        state_q <= IDLE;
                        we_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        addr_q <= cnt_q[ADDR_WIDTH-1:0];
                        data_q <= color_q;
                        we_q   <= 1'b1;
                        cnt_q  <= cnt_q + CNT_ONE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Grant decision; also taken on the edge that ends a clear.
            if (arb_en) begin
                we_q <= pick_w;
                if (pick_w) begin
                    w_gnt_q  <= 1'b1;
                    prio_w_q <= 1'b0;
                    addr_q   <= bus.w_addr;
                    data_q   <= bus.w_data;
                end
                if (pick_r) begin
                    r_gnt_q  <= 1'b1;
                    prio_w_q <= 1'b1;
                    addr_q   <= bus.r_addr;
                end
            end
        end
    end

    assign bus.clr_busy   = busy_q;
    assign bus.clr_done   = done_q;
    assign bus.w_gnt      = w_gnt_q;
    assign bus.r_gnt      = r_gnt_q;
    assign bus.r_valid    = r_valid_q;
    assign bus.r_data     = r_data_q;
    assign bus.mem_addr_a = addr_q;
    assign bus.mem_data_a = data_q;
    assign bus.mem_we_a   = we_q;
endmodule

// File: doc/vga_mem_port_a_arbiter.md
Name: vga_mem_port_a_arbiter

Overview:
- Owns port A of the dual-port VGA frame memory; port B stays with the VGA scan-out.
- Shares port A between three users:
  - a game-logic write requester;
  - a game-logic read requester (e.g. collision checks);
  - a built-in screen-clear engine that fills the whole memory with one colour.
- All memory-side outputs are registered.

Parameters:
- DATA_WIDTH, 8, pixel/colour word width; must match the frame memory.
- ADDR_WIDTH, 16, frame memory address width; the clear engine covers all 2**ADDR_WIDTH words.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr_start  in  1  request a full-memory clear.
- clr_color  in  DATA_WIDTH  fill value, sampled with clr_start.
- clr_busy  out  1  clear in progress.
- clr_done  out  1  one-cycle pulse when the clear finishes.
- w_req  in  1  write request; w_addr/w_data held stable until granted.
- w_addr  in  ADDR_WIDTH  write address.
- w_data  in  DATA_WIDTH  write data.
- w_gnt  out  1  one-cycle write grant.
- r_req  in  1  read request; r_addr held stable until granted.
- r_addr  in  ADDR_WIDTH  read address.
- r_gnt  out  1  one-cycle read grant.
- r_valid  out  1  one-cycle pulse; r_data valid.
- r_data  out  DATA_WIDTH  read result, held until the next r_valid.
- mem_addr_a  out  ADDR_WIDTH  to memory addr_a.
- mem_data_a  out  DATA_WIDTH  to memory data_a.
- mem_we_a  out  1  to memory we_a.
- mem_q_a  in  DATA_WIDTH  from memory q_a (registered in memory, 1-cycle latency).

Behaviour:
- Reset (async, immediate): every output 0; state IDLE; round-robin pointer favours write; any clear is aborted and any in-flight read is dropped (no r_valid).
- FSM states:
  - IDLE/SERVE: arbitrate requesters.
  - CLEAR: issue fill writes.
- Decision edge: every rising edge k, from IDLE/SERVE, in priority order:
  - clr_start=1: latch clr_color; enter CLEAR; mem_addr_a=0, mem_we_a=1, mem_data_a=colour, clr_busy=1; no grant this edge even if requests are pending.
  - Otherwise choose among eligible requesters.
    - A requester is eligible if its req=1 and its gnt is not currently high. This gives no back-to-back grants to the same requester, so a requester gets at most one grant per 2 cycles.
    - Both eligible: grant the one not granted last (round-robin); the pointer updates on every grant.
    - Write grant: w_gnt=1, mem_addr_a=w_addr, mem_data_a=w_data, mem_we_a=1.
    - Read grant: r_gnt=1, mem_addr_a=r_addr, mem_we_a=0.
    - No grant: mem_we_a=0; mem_addr_a and mem_data_a hold.
- Gnt timing: gnt is high for exactly one cycle, after edge k. A requester samples gnt at edge k+1 and may then change addr/data or drop req.
- Read latency:
  - Memory samples the address at edge k+1.
  - The block captures mem_q_a into r_data at edge k+2 with r_valid=1.
  - r_valid therefore asserts 2 cycles after r_gnt asserts.
  - Reads are pipelined; back-to-back reads from alternating grants yield back-to-back r_valid.
- CLEAR:
  - Each edge increments mem_addr_a, mem_we_a=1.
  - The edge after address 2**ADDR_WIDTH-1 has been driven sets mem_we_a=0, clr_busy=0, clr_done=1 (one cycle) and returns to IDLE.
  - clr_busy stays high for exactly 2**ADDR_WIDTH cycles.
  - No grants while clr_busy=1; requests wait and are arbitrated from the edge that clears clr_busy.
  - clr_start while busy is ignored; no restart and no re-latch of colour.
  - The address counter is ADDR_WIDTH+1 bits internally so the last address is detected without wrap ambiguity.
- In-flight read when a clear starts: that read still completes; r_valid fires with the pre-clear data.

Test Plan:
- Reset: assert rst mid-operation -> all outputs 0 immediately. Release, then w_req=1, r_req=1 together -> w_gnt first.
- Single write: w_req=1, w_addr=0x0123, w_data=0x5A -> w_gnt the cycle after the edge; mem_we_a=1, mem_addr_a=0x0123, mem_data_a=0x5A for one cycle. Port-B readback gives 0x5A.
- Read latency: memory preloaded 0x77 at 0x0040; r_req with r_addr=0x0040 -> r_valid exactly 2 cycles after r_gnt, r_data=0x77.
- Contention: w_req and r_req held high for 8 cycles -> grants alternate W,R,W,R. No requester is granted on consecutive cycles. mem port active every cycle.
- Clear: ADDR_WIDTH=4, clr_color=0x3C, clr_start pulse -> clr_busy high for 16 cycles, addresses 0..15 written with 0x3C, then clr_done pulse. w_req asserted mid-clear is granted only after clr_busy falls.
- Reset mid-clear at address 7 -> mem_we_a=0 and clr_busy=0 immediately; addresses 8..15 retain old data; no clr_done.
